// File: rtl/path_sampler_pkg.sv
// ============================================================================
// Package  : path_sampler_pkg
// Desc     : Shared state encoding and default widths for the path sampler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package path_sampler_pkg;

  localparam int TRIAL_W_DEF        = 16;
  localparam int COUNT_W_DEF        = 16;
  localparam int RECOVER_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREP    = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } sampler_state_t;

endpackage

`default_nettype wire

// File: rtl/path_delay_sampler_if.sv
// ============================================================================
// Interface : path_delay_sampler_if
// Desc      : Run request / result bundle between readout logic and sampler.
//             SAMPLER_TRACE_EN adds the traceBits history word.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface path_delay_sampler_if
  import path_sampler_pkg::*;
#(
  parameter int TRIAL_W = TRIAL_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) ();

  logic               start;
  logic [TRIAL_W-1:0] numTrials;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] faultCount;
  logic               saturated;

`ifdef SAMPLER_TRACE_EN
  logic [31:0]        traceBits;

  modport master (
    output start, numTrials,
    input  busy, done, faultCount, saturated, traceBits
  );

  modport slave (
    input  start, numTrials,
    output busy, done, faultCount, saturated, traceBits
  );
`else
  modport master (
    output start, numTrials,
    input  busy, done, faultCount, saturated
  );

  modport slave (
    input  start, numTrials,
    output busy, done, faultCount, saturated
  );
`endif

endinterface

`default_nettype wire

// File: rtl/path_sampler_sat_counter.sv
// ============================================================================
// Module   : path_sampler_sat_counter
// Desc     : Up-counter with synchronous clear that sticks at all-ones and
//            flags saturation when it gets there.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module path_sampler_sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             en,
  output logic      [WIDTH-1:0] count,
  output logic                  sat
);

  localparam logic [WIDTH-1:0] C_MAX = '1;
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (en && (r_count != C_MAX)) begin
      r_count <= r_count + C_ONE;
      // Flag goes up on the same edge the count lands on all-ones.
      if (r_count == (C_MAX - C_ONE)) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule

`default_nettype wire

// File: rtl/path_delay_sampler.sv
// ============================================================================
// Module   : path_delay_sampler
// Desc     : Launches a toggle into a chained delay path and captures its far
//            end one clock later, counting late captures over a trial run.
//            Optional macro SAMPLER_TRACE_EN adds the traceBits history.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module path_delay_sampler
  import path_sampler_pkg::*;
#(
  parameter int TRIAL_W        = TRIAL_W_DEF,
  parameter int COUNT_W        = COUNT_W_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,  // legal 1..255
  parameter int INVERTING      = 0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  path_delay_sampler_if.slave bus,
  output logic               pathInput,
  input  wire logic          pathResult
);

  localparam logic [7:0]         C_TIMER_LOAD = 8'(RECOVER_CYCLES - 1);
  localparam logic [TRIAL_W-1:0] C_TRIAL_ONE  = {{(TRIAL_W-1){1'b0}}, 1'b1};
  localparam logic               C_INV        = (INVERTING != 0);

  sampler_state_t     r_state;
  logic [7:0]         r_timer;
  logic [TRIAL_W-1:0] r_remaining;
  logic               r_expected;
  logic               r_busy;
  logic               r_done;

  // Launch and capture flops bound the timed path; they must survive synthesis as-is.
  (* keep = "true", dont_touch = "true" *) logic r_path_in;
  (* keep = "true", dont_touch = "true" *) logic r_cap;

  logic               w_accept;
  logic               w_mismatch;
  logic               w_count_en;
  logic [COUNT_W-1:0] w_fault_count;
  logic               w_saturated;

  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_mismatch = r_cap ^ r_expected;
  assign w_count_en = (r_state == ST_CHECK) && w_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_remaining <= '0;
      r_expected  <= 1'b0;
      r_cap       <= 1'b0;
      r_path_in   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.numTrials != '0) begin
              r_remaining <= bus.numTrials;
              r_timer     <= C_TIMER_LOAD;
              r_busy      <= 1'b1;
              r_state     <= ST_PREP;
            end else begin
              r_state     <= ST_DONE;
            end
          end
        end

        ST_PREP: begin
          if (r_timer == 8'd0) begin
            r_state <= ST_LAUNCH;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end

        ST_LAUNCH: begin
          r_path_in  <= ~r_path_in;
          r_expected <= ~r_path_in ^ C_INV;
          r_state    <= ST_CAPTURE;
        end

        // Raw sample of the chain end, one period after the launch edge.
        ST_CAPTURE: begin
          r_cap   <= pathResult;
          r_state <= ST_CHECK;
        end

        ST_CHECK: begin
          r_remaining <= r_remaining - C_TRIAL_ONE;
          if (r_remaining == C_TRIAL_ONE) begin
            r_state <= ST_DONE;
          end else begin
            r_timer <= C_TIMER_LOAD;
            r_state <= ST_PREP;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  path_sampler_sat_counter #(
    .WIDTH (COUNT_W)
  ) u_fault_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (w_count_en),
    .count (w_fault_count),
    .sat   (w_saturated)
  );

`ifdef SAMPLER_TRACE_EN
  logic [31:0] r_trace;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trace <= '0;
    end else if (w_accept) begin
      r_trace <= '0;
    end else if (r_state == ST_CHECK) begin
      r_trace <= {r_trace[30:0], w_mismatch};
    end
  end

  assign bus.traceBits = r_trace;
`endif

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.faultCount = w_fault_count;
  assign bus.saturated  = w_saturated;
  assign pathInput      = r_path_in;

endmodule

`default_nettype wire

// File: tb/tb_path_delay_sampler.sv
// ============================================================================
// Module   : tb_path_delay_sampler
// Desc     : Scoreboard bench: two samplers (plain and inverting/4-bit count)
//            around behavioural chain models with selectable lateness.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_path_delay_sampler;
  import path_sampler_pkg::*;

  localparam int T      = 10;
  localparam int R      = 8;
  localparam int M_ZERO = 0;  // chain arrives within the capture period
  localparam int M_LATE = 1;  // chain arrives 1.5 periods after launch
  localparam int M_ODD  = 2;  // late only on the 2nd, 4th, ... trial of a run

  typedef struct {
    int faults;
    int sat;
    int lat;
    int busy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #(T/2) clk = ~clk;

  path_delay_sampler_if #(.TRIAL_W(16), .COUNT_W(16)) bus_a ();
  path_delay_sampler_if #(.TRIAL_W(16), .COUNT_W(4))  bus_b ();

  wire  [1:0] pin;
  wire  [1:0] pres;
  logic [1:0] d1 = '0;
  logic [1:0] d2 = '0;
  int tog0 = 0, tog1 = 0, base0 = 0, base1 = 0, mode0 = 0, mode1 = 0;

  path_delay_sampler #(
    .TRIAL_W(16), .COUNT_W(16), .RECOVER_CYCLES(R), .INVERTING(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .pathInput(pin[0]), .pathResult(pres[0])
  );

  path_delay_sampler #(
    .TRIAL_W(16), .COUNT_W(4), .RECOVER_CYCLES(R), .INVERTING(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .pathInput(pin[1]), .pathResult(pres[1])
  );

  // Late path: d2 follows the launch 1.5 periods later, so the capture edge still sees the old level.
  always @(posedge clk) d1 <= pin;
  always @(negedge clk) d2 <= d1;
  always @(pin[0]) tog0 = tog0 + 1;
  always @(pin[1]) tog1 = tog1 + 1;

  function automatic logic late_sel(int m, int k);
    return (m == M_LATE) || ((m == M_ODD) && (k > 0) && ((k % 2) == 0));
  endfunction

  assign pres[0] = late_sel(mode0, tog0 - base0) ?  d2[0] :  pin[0];
  assign pres[1] = late_sel(mode1, tog1 - base1) ? ~d2[1] : ~pin[1];

  exp_t q_a[$];
  exp_t q_b[$];
  time  t_start_a = 0;
  time  t_start_b = 0;
  int   checks    = 0;
  int   failures  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic score(string p, exp_t e, logic [15:0] fc, logic sat, logic busy,
                       time ts, int bc);
    check({p, "_fault_count"},  fc,                e.faults);
    check({p, "_saturated"},    sat,               e.sat);
    check({p, "_done_latency"}, ($time - 1 - ts) / T, e.lat);
    check({p, "_busy_cycles"},  bc,                e.busy);
    check({p, "_busy_at_done"}, busy,              0);
  endtask

  initial begin : monitor
    int   bc_a;
    int   bc_b;
    exp_t e;
    bc_a = 0;
    bc_b = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bc_a = 0;
        bc_b = 0;
      end else begin
        if (bus_a.busy) bc_a++;
        if (bus_b.busy) bc_b++;
        if (bus_a.done) begin
          if (q_a.size() == 0) check("a_unexpected_done", 1, 0);
          else begin
            e = q_a.pop_front();
            score("a", e, bus_a.faultCount, bus_a.saturated, bus_a.busy, t_start_a, bc_a);
          end
          bc_a = 0;
        end
        if (bus_b.done) begin
          if (q_b.size() == 0) check("b_unexpected_done", 1, 0);
          else begin
            e = q_b.pop_front();
            score("b", e, 16'(bus_b.faultCount), bus_b.saturated, bus_b.busy, t_start_b, bc_b);
          end
          bc_b = 0;
        end
      end
    end
  end

  task automatic run(int which, int n, int m, int ef, int es, int lat, int bc, bit push);
    exp_t e;
    e.faults = ef; e.sat = es; e.lat = lat; e.busy = bc;
    @(negedge clk);
    if (which == 0) begin
      mode0 = m; base0 = tog0;
      bus_a.numTrials = 16'(n); bus_a.start = 1'b1;
      if (push) q_a.push_back(e);
      @(posedge clk); t_start_a = $time;
      @(negedge clk); bus_a.start = 1'b0;
    end else begin
      mode1 = m; base1 = tog1;
      bus_b.numTrials = 16'(n); bus_b.start = 1'b1;
      if (push) q_b.push_back(e);
      @(posedge clk); t_start_b = $time;
      @(negedge clk); bus_b.start = 1'b0;
    end
  endtask

  task automatic wait_done(int which);
    for (int i = 0; i < 3000; i++) begin
      if (((which == 0) ? q_a.size() : q_b.size()) == 0) break;
      @(negedge clk);
    end
    if (which == 0) begin
      check("a_run_completed", q_a.size(), 0);
      q_a.delete();
    end else begin
      check("b_run_completed", q_b.size(), 0);
      q_b.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus_a.start = 1'b0; bus_a.numTrials = '0;
    bus_b.start = 1'b0; bus_b.numTrials = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",        bus_a.busy,       0);
    check("rst_done",        bus_a.done,       0);
    check("rst_fault_count", bus_a.faultCount, 0);
    check("rst_saturated",   bus_a.saturated,  0);
    check("rst_path_input",  pin,              0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean non-inverting chain: 10 trials, no faults, 10*11+1 cycles.
    run(0, 10, M_ZERO, 0, 0, 111, 111, 1'b1);
    wait_done(0);
    check("a_zero_launch_edges", tog0 - base0, 10);

    // Chain 1.5 periods slow: every capture is late.
    run(0, 10, M_LATE, 10, 0, 111, 111, 1'b1);
    wait_done(0);
    check("a_late_launch_edges", tog0 - base0, 10);

    // Zero-trial request: done one cycle after start, busy never set.
    run(0, 0, M_ZERO, 0, 0, 1, 0, 1'b1);
    wait_done(0);
    check("a_empty_launch_edges", tog0 - base0, 0);

    // Start pulses mid-run and during DONE must not queue a second run.
    run(0, 3, M_LATE, 3, 0, 34, 34, 1'b1);
    bus_a.numTrials = 16'd7;
    for (int i = 1; i <= 33; i++) begin
      bus_a.start = (i == 5) || (i == 20) || (i == 33);
      @(negedge clk);
    end
    bus_a.start = 1'b0;
    wait_done(0);
    repeat (5) @(negedge clk);
    check("a_ignored_start_busy", bus_a.busy, 0);
    check("a_ignored_launch_edges", tog0 - base0, 3);

    // Reset during CAPTURE of trial 3 drops the partial run immediately.
    run(0, 10, M_LATE, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      if ((tog0 - base0) >= 3) break;
      @(negedge clk);
    end
    check("a_reached_trial3", tog0 - base0, 3);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",        bus_a.busy,       0);
    check("midrst_done",        bus_a.done,       0);
    check("midrst_fault_count", bus_a.faultCount, 0);
    check("midrst_saturated",   bus_a.saturated,  0);
    check("midrst_path_input",  pin[0],           0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, 4, M_LATE, 4, 0, 45, 45, 1'b1);
    wait_done(0);

    // Late on trials 2 and 4 only.
    run(0, 4, M_ODD, 2, 0, 45, 45, 1'b1);
    wait_done(0);
`ifdef SAMPLER_TRACE_EN
    check("a_trace_bits", bus_a.traceBits, 32'b0101);
`endif

    // Inverting chain, clean: no faults.
    run(1, 4, M_ZERO, 0, 0, 45, 45, 1'b1);
    wait_done(1);

    // 4-bit counter, 20 late trials: sticks at 15 and flags saturation.
    run(1, 20, M_LATE, 15, 1, 221, 221, 1'b1);
    wait_done(1);
    check("b_sat_launch_edges", tog1 - base1, 20);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
